phase_sequence_monitor: RTL and testbench

- Receiving end of the five-phase clock bus in the multicycle processor.
- Samples the one-hot Phases[4:0] vector every cycle and re-encodes it to a stage index.
- Checks legal ordering: 0→1→2→3→4→0; locks onto the sequence and flags sequence errors.
- Counts completed instruction periods for the control unit and the debug counters.

---
 rtl/phase_sequence_monitor.sv | 157 +++++++++++++++
 tb/tb_phase_sequence_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/phase_sequence_monitor.sv
// phase_sequence_monitor
//   Receiving end of the five-phase clock bus. Re-encodes the one-hot phase
//   vector to a stage index, checks the 0->1->2->3->4->0 ordering, locks
//   after LOCK_PERIODS clean periods, and counts completed periods and
//   sequence errors.
//
//   Optional build macro PHASE_MON_HOLD_EN: when defined, a one-hot vector
//   equal to the previously accepted phase (a stalled phase) is legal in
//   ACQUIRE and LOCKED and changes nothing.
//
// Ports
//   CLK          clock, all state on rising edge
//   RST          synchronous reset, active low
//   Phases[4:0]  one-hot phase bus
//   stage_idx    registered index 0..4, 3'b111 when Phases is not one-hot
//   phase_valid  registered: Phases was exactly one-hot
//   locked       high while in LOCKED
//   period_done  pulse on a correct phase 4 while LOCKED
//   seq_err      pulse on a sequence violation while LOCKED
//   instr_cnt    period_done count, wraps
//   err_cnt      seq_err count, saturates
module phase_sequence_monitor #(
    parameter int CNT_W        = 16,
    parameter int ERR_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Phases,
    output logic [2:0]       stage_idx,
    output logic             phase_valid,
    output logic             locked,
    output logic             period_done,
    output logic             seq_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED, S_ERROR} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_PERIODS);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_expected, w_exp_nxt;
    logic [3:0]       r_pcnt, w_pcnt_nxt;
    logic [2:0]       r_stage_idx;
    logic             r_phase_valid, r_period_done, r_seq_err;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    logic [2:0] w_idx, w_exp_adv;
    logic [3:0] w_pcnt_inc;
    logic       w_valid, w_match, w_hold, w_pdone, w_serr;

    // One-hot decode; anything else (zero or multi-bit) is invalid.
    always_comb begin
        w_valid = 1'b1;
        w_idx   = 3'd7;
        case (Phases)
            5'b00001: w_idx = 3'd0;
            5'b00010: w_idx = 3'd1;
            5'b00100: w_idx = 3'd2;
            5'b01000: w_idx = 3'd3;
            5'b10000: w_idx = 3'd4;
            default:  w_valid = 1'b0;
        endcase
    end

    assign w_match    = w_valid && (w_idx == r_expected);
    assign w_exp_adv  = (r_expected == 3'd4) ? 3'd0 : r_expected + 3'd1;
    assign w_pcnt_inc = r_pcnt + 4'd1;

`ifdef PHASE_MON_HOLD_EN
    // While tracking, the last accepted phase is always the one just before
    // expected, so no separate register is needed for it.
    logic [2:0] w_prev;
    assign w_prev = (r_expected == 3'd0) ? 3'd4 : r_expected - 3'd1;
    assign w_hold = w_valid && (w_idx == w_prev);
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_expected;
        w_pcnt_nxt  = r_pcnt;
        w_pdone     = 1'b0;
        w_serr      = 1'b0;
        case (r_state)
            S_UNLOCKED, S_ERROR: begin
                if (Phases == 5'b00001) begin
                    w_state_nxt = S_ACQUIRE;
                    w_exp_nxt   = 3'd1;
                    w_pcnt_nxt  = 4'd0;
                end
            end
            S_ACQUIRE: begin
                if (w_match) begin
                    w_exp_nxt = w_exp_adv;
                    if (w_idx == 3'd4) begin
                        w_pcnt_nxt = w_pcnt_inc;
                        if (w_pcnt_inc == LOCK_N)
                            w_state_nxt = S_LOCKED;
                    end
                end else if (!w_hold) begin
                    // Losing the sequence before lock is silent.
                    w_state_nxt = S_UNLOCKED;
                end
            end
            S_LOCKED: begin
                if (w_match) begin
                    w_exp_nxt = w_exp_adv;
                    w_pdone   = (w_idx == 3'd4);
                end else if (!w_hold) begin
                    w_serr      = 1'b1;
                    w_state_nxt = S_ERROR;
                end
            end
            default: w_state_nxt = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= S_UNLOCKED;
            r_expected    <= 3'd0;
            r_pcnt        <= 4'd0;
            r_stage_idx   <= 3'b111;
            r_phase_valid <= 1'b0;
            r_period_done <= 1'b0;
            r_seq_err     <= 1'b0;
            r_instr_cnt   <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_expected    <= w_exp_nxt;
            r_pcnt        <= w_pcnt_nxt;
            r_stage_idx   <= w_idx;
            r_phase_valid <= w_valid;
            r_period_done <= w_pdone;
            r_seq_err     <= w_serr;
            if (w_pdone)
                r_instr_cnt <= r_instr_cnt + 1'b1;
            if (w_serr && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign stage_idx   = r_stage_idx;
    assign phase_valid = r_phase_valid;
    assign locked      = (r_state == S_LOCKED);
    assign period_done = r_period_done;
    assign seq_err     = r_seq_err;
    assign instr_cnt   = r_instr_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// Randomized + directed bench for phase_sequence_monitor. The reference model
// tracks the run length of consecutive accepted phases since phase 0; lock is
// simply "run length has reached 5*LOCK_PERIODS".
module tb_phase_sequence_monitor;

    localparam int CNT_W = 8;
    localparam int ERR_W = 8;
    localparam int LP    = 2;
`ifdef PHASE_MON_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [4:0]       Phases = 5'b0;
    logic [2:0]       stage_idx;
    logic             phase_valid, locked, period_done, seq_err;
    logic [CNT_W-1:0] instr_cnt;
    logic [ERR_W-1:0] err_cnt;

    phase_sequence_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOCK_PERIODS(LP)) dut (
        .CLK(CLK), .RST(RST), .Phases(Phases), .stage_idx(stage_idx),
        .phase_valid(phase_valid), .locked(locked), .period_done(period_done),
        .seq_err(seq_err), .instr_cnt(instr_cnt), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_err = 0, cyc = 0;
    int g = 0;   // next phase the stimulus generator would emit

    // reference model state
    bit m_track = 0;
    int m_run = 0;
    int m_sidx = 7, m_pv = 0, m_pd = 0, m_se = 0, m_ic = 0, m_ec = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int m_locked();
        return (m_track && m_run >= 5*LP) ? 1 : 0;
    endfunction

    task automatic model(input logic [4:0] ph, input logic rst);
        int  idx;
        bit  oh, was_locked;
        if (!rst) begin
            m_track = 0; m_run = 0; m_sidx = 7; m_pv = 0; m_pd = 0; m_se = 0;
            m_ic = 0; m_ec = 0;
            return;
        end
        oh = ($countones(ph) == 1);
        idx = 7;
        if (oh) for (int b = 0; b < 5; b++) if (ph[b]) idx = b;
        m_sidx = idx; m_pv = oh; m_pd = 0; m_se = 0;
        was_locked = (m_locked() == 1);
        if (!m_track) begin
            if (ph == 5'b00001) begin m_track = 1; m_run = 1; end
        end else if (oh && idx == m_run % 5) begin
            if (was_locked && idx == 4) begin m_pd = 1; m_ic = (m_ic + 1) % (1 << CNT_W); end
            m_run++;
            if (m_run >= 5*LP + 5) m_run -= 5;
        end else if (HOLD && oh && idx == (m_run + 4) % 5) begin
            // stalled phase: nothing changes
        end else begin
            if (was_locked) begin
                m_se = 1;
                if (m_ec < (1 << ERR_W) - 1) m_ec++;
            end
            m_track = 0;
        end
    endtask

    task automatic step(input logic [4:0] ph, input logic rst);
        @(negedge CLK);
        Phases = ph; RST = rst;
        @(posedge CLK);
        cyc++;
        model(ph, rst);
        #1;
        chk("stage_idx",   32'(stage_idx),   32'(m_sidx));
        chk("phase_valid", 32'(phase_valid), 32'(m_pv));
        chk("locked",      32'(locked),      32'(m_locked()));
        chk("period_done", 32'(period_done), 32'(m_pd));
        chk("seq_err",     32'(seq_err),     32'(m_se));
        chk("instr_cnt",   32'(instr_cnt),   32'(m_ic));
        chk("err_cnt",     32'(err_cnt),     32'(m_ec));
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            step(5'(1 << g), 1'b1);
            g = (g + 1) % 5;
        end
    endtask

    task automatic do_reset();
        step(5'b00000, 1'b0);
        g = 0;
    endtask

    int e0, i0, r;

    initial begin
        // reset state
        do_reset(); do_reset();
        chk("rst_idx", 32'(stage_idx), 32'd7);
        chk("rst_locked", 32'(locked), 32'd0);

        // clean sequence: lock on the 10th phase, then 3 periods
        run_seq(9);
        chk("pre_lock", 32'(locked), 32'd0);
        run_seq(1);
        chk("lock10", 32'(locked), 32'd1);
        run_seq(15);
        chk("instr3", 32'(instr_cnt), 32'd3);
        chk("err0", 32'(err_cnt), 32'd0);

        // phase 2 where phase 1 expected
        run_seq(1);
        step(5'b00100, 1'b1);
        chk("inj_err", 32'(err_cnt), 32'd1);
        chk("inj_unlock", 32'(locked), 32'd0);
        g = 0; run_seq(10);
        chk("relock", 32'(locked), 32'd1);
        chk("recov_instr", 32'(instr_cnt), 32'd3);

        // invalid vectors while locked
        step(5'b00011, 1'b1);
        chk("multi_idx", 32'(stage_idx), 32'd7);
        chk("multi_serr", 32'(seq_err), 32'd1);
        g = 0; run_seq(10);
        step(5'b00000, 1'b1);
        chk("zero_pv", 32'(phase_valid), 32'd0);
        chk("zero_serr", 32'(seq_err), 32'd1);
        g = 0; run_seq(10);

        // hold phase 2 for 3 cycles while locked
        run_seq(2);
        e0 = err_cnt;
        step(5'b00100, 1'b1); step(5'b00100, 1'b1); step(5'b00100, 1'b1);
        chk("hold_locked", 32'(locked), HOLD ? 32'd1 : 32'd0);
        chk("hold_err", 32'(err_cnt), 32'(e0 + (HOLD ? 0 : 1)));
        g = 3; run_seq(17);

        // reset pulse while locked at phase 3
        do_reset(); run_seq(13);
        step(5'b01000, 1'b0);
        chk("mid_rst_idx", 32'(stage_idx), 32'd7);
        chk("mid_rst_cnt", 32'(instr_cnt), 32'd0);
        step(5'b10000, 1'b1);
        chk("mid_rst_unl", 32'(locked), 32'd0);
        g = 0; run_seq(10);
        chk("mid_rst_relock", 32'(locked), 32'd1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 85) run_seq(1);
            else if (r < 91) step(5'(1 << ((g + 4) % 5)), 1'b1);
            else if (r < 96) step(5'($urandom_range(0, 31)), 1'b1);
            else if (r < 98) begin g = 0; run_seq(1); end
            else begin step(5'($urandom_range(0, 31)), 1'b0); g = 0; end
        end

        // error counter saturation
        do_reset();
        for (int k = 0; k < 300; k++) begin
            g = 0; run_seq(10);
            step(5'b00000, 1'b1);
        end
        chk("err_sat", 32'(err_cnt), 32'd255);

        // instruction counter wrap: 2^CNT_W + 1 periods after lock
        do_reset();
        i0 = (1 << CNT_W) + 1;
        run_seq(10 + 5 * i0);
        chk("instr_wrap", 32'(instr_cnt), 32'd1);
        chk("wrap_locked", 32'(locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
